// File: rtl/add100_seq.sv
// Sequential wide adder: accepts two WIDTH-bit operands and ripples through them
// SLICE bits per clock, presenting sum, final carry and per-slice carries when done.
module add100_seq #(
    parameter int WIDTH = 100,
    parameter int SLICE = 25,
    localparam int NS = WIDTH / SLICE,
    localparam int KW = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [NS-1:0]    slice_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            r_state;
    logic [KW-1:0]    r_k;
    logic             r_c;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [NS-1:0]    r_sliceCout;
    logic             r_inReady;
    logic             r_outValid;

    logic [SLICE-1:0] w_sliceA;
    logic [SLICE-1:0] w_sliceB;
    logic [SLICE:0]   w_sliceSum;
    logic             w_lastSlice;

    // Only the captured operand copies feed the adder, so a/b/cin never reach sum combinationally.
    assign w_sliceA    = r_a[r_k*SLICE +: SLICE];
    assign w_sliceB    = r_b[r_k*SLICE +: SLICE];
    assign w_sliceSum  = {1'b0, w_sliceA} + {1'b0, w_sliceB} + {{SLICE{1'b0}}, r_c};
    assign w_lastSlice = (r_k == KW'(NS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_c         <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_sliceCout <= '0;
            r_inReady   <= 1'b1;
            r_outValid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_c       <= cin;
                        r_k       <= '0;
                        r_state   <= CALC;
                        r_inReady <= 1'b0;
                    end
                end
                CALC: begin
                    r_sum[r_k*SLICE +: SLICE] <= w_sliceSum[SLICE-1:0];
                    r_sliceCout[r_k]          <= w_sliceSum[SLICE];
                    r_c                       <= w_sliceSum[SLICE];
                    if (w_lastSlice) begin
                        r_cout     <= w_sliceSum[SLICE];
                        r_state    <= DONE;
                        r_outValid <= 1'b1;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                DONE: begin
                    // Result stays frozen until the consumer takes it.
                    if (out_ready) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_inReady;
    assign out_valid  = r_outValid;
    assign sum        = r_sum;
    assign cout       = r_cout;
    assign slice_cout = r_sliceCout;

endmodule

// File: tb/tb_add100_seq.sv
// Directed and randomised self-checking bench for the sequential wide adder.
module tb_add100_seq;

    localparam int W  = 100;
    localparam int S  = 25;
    localparam int NS = W / S;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic [NS-1:0] slice_cout;

    int checks;
    int failures;

    add100_seq #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .slice_cout(slice_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one operand set while in_ready is high and returns at the negedge after acceptance.
    task automatic startOp(input logic [W-1:0] opA, input logic [W-1:0] opB, input logic opCin,
                           output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        a = opA;
        b = opB;
        cin = opCin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts negedges until out_valid rises, giving up after a fixed budget.
    task automatic waitResult(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Independent reference: whole-word add plus per-slice ripple carries.
    function automatic logic [NS-1:0] refSliceCarry(input logic [W-1:0] x, input logic [W-1:0] y,
                                                    input logic c0);
        logic [S:0] t;
        logic c;
        logic [NS-1:0] r;
        c = c0;
        r = '0;
        for (int k = 0; k < NS; k++) begin
            t = {1'b0, x[k*S +: S]} + {1'b0, y[k*S +: S]} + {{S{1'b0}}, c};
            c = t[S];
            r[k] = c;
        end
        return r;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_handshake out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        checks++;
        if (sum !== '0 || cout !== 1'b0 || slice_cout !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs sum=%h cout=%b slice_cout=%b required 0", sum, cout, slice_cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero;
        bit ok;
        int n;
        out_ready = 1'b0;
        startOp('0, '0, 1'b0, ok);
        waitResult(n);
        checks++;
        if (!ok || n != NS) begin
            failures++;
            $display("[TB] FAIL zero_latency accepted=%0d cycles=%0d required %0d", ok, n, NS);
        end
        checks++;
        if (sum !== '0 || cout !== 1'b0 || slice_cout !== 4'b0000 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_result sum=%h cout=%b sc=%b in_ready=%b required 0/0/0000/0",
                     sum, cout, slice_cout, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_return in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_all_ones;
        bit ok;
        int n;
        startOp({W{1'b1}}, '0, 1'b1, ok);
        waitResult(n);
        checks++;
        if (!ok || n != NS || sum !== '0 || cout !== 1'b1 || slice_cout !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL all_ones cycles=%0d sum=%h cout=%b sc=%b required 4/0/1/1111",
                     n, sum, cout, slice_cout);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_slice_carry;
        bit ok;
        int n;
        logic [W-1:0] expSum;
        expSum = '0;
        expSum[S] = 1'b1;
        startOp({{(W-S){1'b0}}, {S{1'b1}}}, {{(W-1){1'b0}}, 1'b1}, 1'b0, ok);
        waitResult(n);
        checks++;
        if (!ok || n != NS || sum !== expSum || cout !== 1'b0 || slice_cout !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL slice_carry cycles=%0d sum=%h cout=%b sc=%b required %h/0/0001",
                     n, sum, cout, slice_cout, expSum);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (sum !== expSum || slice_cout !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL slice_carry_retain sum=%h sc=%b required %h/0001", sum, slice_cout, expSum);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int n;
        int bad;
        logic [W-1:0] expSum;
        expSum = 100'h0_1234_5678_9ABC_DEF0_0000_0001 + 100'h0_0000_0000_0000_0000_FFFF_FFFF;
        startOp(100'h0_1234_5678_9ABC_DEF0_0000_0001, 100'h0_0000_0000_0000_0000_FFFF_FFFF, 1'b0, ok);
        waitResult(n);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = {W{1'b1}};
            b = {W{1'b1}};
            cin = 1'b1;
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== expSum || cout !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok || n != NS || bad != 0) begin
            failures++;
            $display("[TB] FAIL backpressure_hold cycles=%0d unstable_cycles=%0d sum=%h required 4/0/%h",
                     n, bad, sum, expSum);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== expSum) begin
            failures++;
            $display("[TB] FAIL backpressure_accept out_valid=%b in_ready=%b sum=%h required 0/1/%h",
                     out_valid, in_ready, sum, expSum);
        end
    endtask

    task automatic test_reset_abort;
        bit ok;
        int n;
        startOp({W{1'b1}}, 100'h1234, 1'b0, ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_reset out_valid=%b sum=%h cout=%b in_ready=%b required 0/0/0/1",
                     out_valid, sum, cout, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        startOp(100'd5, 100'd7, 1'b1, ok);
        waitResult(n);
        checks++;
        if (!ok || n != NS || sum !== 100'd13 || cout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_next cycles=%0d sum=%0d cout=%b required 4/13/0", n, sum, cout);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit ok;
        int n;
        int hold;
        logic [W-1:0] x, y;
        logic c0;
        logic [W:0] expFull;
        logic [NS-1:0] expSc;
        for (int op = 0; op < 1000; op++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            y = (op % 4 == 0) ? ~x : {$urandom, $urandom, $urandom, $urandom};
            c0 = 1'($urandom_range(0, 1));
            expFull = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c0};
            expSc = refSliceCarry(x, y, c0);
            startOp(x, y, c0, ok);
            waitResult(n);
            checks++;
            if (!ok || n != NS || {cout, sum} !== expFull) begin
                failures++;
                $display("[TB] FAIL b2b_sum op=%0d cycles=%0d got=%h required %h", op, n, {cout, sum}, expFull);
            end
            checks++;
            if (slice_cout !== expSc) begin
                failures++;
                $display("[TB] FAIL b2b_slice op=%0d got=%b required %b", op, slice_cout, expSc);
            end
            hold = 0;
            do begin
                out_ready = (hold >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                @(negedge clk);
                hold++;
            end while (out_valid);
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL b2b_release op=%0d out_valid=%b in_ready=%b required 0/1",
                         op, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_zero;
        test_all_ones;
        test_slice_carry;
        test_backpressure;
        test_reset_abort;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
